// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Purpose  : Sequencer for the 5x5-map / 3x3-kernel convolution MAC datapath.
//            On start it streams 9 kernel words and 25 map words from a
//            1-cycle-latency read memory into the datapath register files,
//            then issues the 9 valid 3x3 window positions over valid/ready
//            with a bounded number of outstanding requests, and tags each
//            returned result with its window index.
// Ports    : clk, rst (sync, active-high)
//            start / busy / done             - host control
//            mem_rd_en, mem_addr, mem_rd_data - shared read memory
//            kern_wr_en, map_wr_en, wr_addr, wr_data - datapath loads
//            win_valid, win_ready, win_row, win_col  - window requests
//            res_valid, res_data             - datapath results (in order)
//            out_valid, out_data, out_index  - tagged results
//            err                             - sticky spurious-result flag
// Revision : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int KERN_BASE = 25,
  parameter int MAP_BASE  = 0,
  parameter int MAX_OUT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              kern_wr_en,
  output logic              map_wr_en,
  output logic [4:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [1:0]        win_row,
  output logic [1:0]        win_col,
  input  logic              res_valid,
  input  logic [7:0]        res_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [8:0]        out_index,
  output logic              err
);

  localparam logic [ADDR_W-1:0] KERN_ADDR = ADDR_W'(KERN_BASE);
  localparam logic [ADDR_W-1:0] MAP_ADDR  = ADDR_W'(MAP_BASE);
  localparam logic [2:0]        MAX_OUTST = 3'(MAX_OUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_KERN = 3'd1,
    S_LD_MAP  = 3'd2,
    S_LD_WAIT = 3'd3,
    S_ISSUE   = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [4:0] ld_cnt;    // element index of the current read
  logic [3:0] iss_cnt;   // windows accepted so far
  logic [2:0] outst;     // windows accepted but not yet returned
  logic [3:0] res_cnt;   // results forwarded so far
  logic       accept;
  logic       res_ok;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    win_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LD_KERN;
      end
      S_LD_KERN: begin
        mem_rd_en = 1'b1;
        mem_addr  = KERN_ADDR + ADDR_W'(ld_cnt);
        if (ld_cnt == 5'd8) state_nxt = S_LD_MAP;
      end
      S_LD_MAP: begin
        mem_rd_en = 1'b1;
        mem_addr  = MAP_ADDR + ADDR_W'(ld_cnt);
        if (ld_cnt == 5'd24) state_nxt = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        // The last map word is being written this cycle.
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        win_valid = (outst < MAX_OUTST);
        if (win_valid && win_ready && (iss_cnt == 4'd8)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_valid && (out_index == 9'd8)) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign accept = win_valid & win_ready;
  // A result with nothing outstanding cannot belong to any window: drop it.
  assign res_ok = res_valid && (outst != 3'd0);

  // Data is taken straight from the memory in the write cycle; gated so the
  // bus is quiet when no write is in progress.
  assign wr_data = (kern_wr_en | map_wr_en) ? mem_rd_data : 8'd0;

  // ---------------------------------------------------------------------------
  // Counters, write pipeline, window position and result tagging
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt     <= '0;
      kern_wr_en <= 1'b0;
      map_wr_en  <= 1'b0;
      wr_addr    <= '0;
      iss_cnt    <= '0;
      win_row    <= '0;
      win_col    <= '0;
      outst      <= '0;
      res_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      err        <= 1'b0;
    end else begin
      // Load read counter: wraps between the kernel and map phases.
      if (state == S_LD_KERN) begin
        ld_cnt <= (ld_cnt == 5'd8) ? 5'd0 : ld_cnt + 5'd1;
      end else if (state == S_LD_MAP) begin
        ld_cnt <= (ld_cnt == 5'd24) ? 5'd0 : ld_cnt + 5'd1;
      end else begin
        ld_cnt <= '0;
      end

      // One-stage write pipeline: target and index follow each read.
      kern_wr_en <= (state == S_LD_KERN);
      map_wr_en  <= (state == S_LD_MAP);
      wr_addr    <= ((state == S_LD_KERN) || (state == S_LD_MAP)) ? ld_cnt : 5'd0;

      if ((state == S_IDLE) && start) begin
        iss_cnt <= '0;
        win_row <= '0;
        win_col <= '0;
        res_cnt <= '0;
      end else if (accept) begin
        iss_cnt <= iss_cnt + 4'd1;
        if (win_col == 2'd2) begin
          win_col <= 2'd0;
          win_row <= (win_row == 2'd2) ? 2'd0 : win_row + 2'd1;
        end else begin
          win_col <= win_col + 2'd1;
        end
      end

      case ({accept, res_ok})
        2'b10:   outst <= outst + 3'd1;
        2'b01:   outst <= outst - 3'd1;
        default: outst <= outst;
      endcase

      out_valid <= res_ok;
      if (res_ok) begin
        out_data  <= res_data;
        out_index <= {5'd0, res_cnt};
        res_cnt   <= res_cnt + 4'd1;
      end

      if (res_valid && (outst == 3'd0)) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the 5x5-map / 3x3-kernel convolution MAC datapath. On a start pulse it streams 9 kernel words and 25 map words from a shared 1-cycle-latency read memory into the datapath's register files. It then issues the 9 valid 3x3 window positions over a valid/ready handshake with bounded outstanding requests, and tags each returned result with its window index. It sits between the top-level host/control logic and the convolution datapath.

Parameters:
ADDR_W, 6, memory address width
KERN_BASE, 25, memory address of kernel element (0,0); kernel is row-major, 9 words
MAP_BASE, 0, memory address of map element (0,0); map is row-major, 25 words
MAX_OUT, 2, max windows issued but not yet returned (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to run one full convolution
busy  out  1  high from the cycle after an accepted start until done pulses
done  out  1  one-cycle pulse after the 9th result is forwarded
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
kern_wr_en  out  1  write strobe into datapath kernel registers
map_wr_en  out  1  write strobe into datapath map buffer
wr_addr  out  5  linear element index: kernel 0..8, map 0..24
wr_data  out  8  data for kern_wr_en/map_wr_en
win_valid  out  1  window request valid
win_ready  in  1  datapath accepts window
win_row  out  2  window top-left row 0..2
win_col  out  2  window top-left col 0..2
res_valid  in  1  datapath result strobe; results return in issue order
res_data  in  8  datapath result, already truncated to 8 bits
out_valid  out  1  tagged result strobe
out_data  out  8  registered copy of res_data
out_index  out  9  window number 0..8 (row*3+col), zero-extended
err  out  1  sticky: res_valid seen with zero outstanding; cleared only by rst

Behaviour:
- Reset: state IDLE. All outputs 0. All counters 0, including the outstanding count and the result count. rst mid-operation aborts immediately. No further writes, requests or done are produced.
- States: IDLE, LD_KERN, LD_MAP, LD_WAIT, ISSUE, DRAIN.
- IDLE: start=1 moves to LD_KERN. start is ignored in every other state.
- LD_KERN: 9 cycles of mem_rd_en=1, mem_addr=KERN_BASE+k for k=0..8. The state then moves to LD_MAP.
- LD_MAP: 25 cycles of mem_rd_en=1, mem_addr=MAP_BASE+m for m=0..24. The state then moves to LD_WAIT.
- Reads and writes are back-to-back with no bubbles. A one-stage write pipeline carries the target, index and data from each read.
- Write timing: kern_wr_en or map_wr_en is asserted the cycle after the matching read. wr_addr is the element index and wr_data=mem_rd_data.
- LD_WAIT: one cycle, covering the final map write. The state then moves to ISSUE.
- Load timing, with start sampled at cycle 0: kernel reads at cycles 1-9, map reads at 10-34, writes at 2-35, win_valid first high at cycle 36.
- ISSUE: win_valid=1 whenever outstanding<MAX_OUT.
  - win_row/win_col step in raster order (0,0),(0,1),(0,2),(1,0)...(2,2). They advance only on win_valid&win_ready.
  - win_row/win_col/win_valid stay stable while win_ready=0.
  - After the 9th acceptance the state moves to DRAIN and win_valid drops the next cycle.
- Outstanding counter: +1 on acceptance, -1 on res_valid. Both in the same cycle leaves it unchanged. It never exceeds MAX_OUT.
- Results are accepted in ISSUE and DRAIN. Each res_valid produces, one cycle later, out_valid=1, out_data=res_data and out_index=result count. The result count then increments.
- DRAIN: when the 9th result has been forwarded (the cycle out_valid for index 8 is high), done pulses in that same cycle. busy drops on the same edge and the state returns to IDLE.
- res_valid with outstanding=0 (any state): the result is ignored, no out_valid is produced, and err is set.
- start in the same cycle as done is ignored. A new run requires start in IDLE.

Test Plan:
- Basic run: memory holds kernel all 1s and map values 0..24; win_ready tied 1; the datapath model returns the window sum 1 cycle after acceptance. Required: kernel writes at cycles 2-10 with wr_addr 0..8; map writes at 11-35; out_index 0..8 with out_data equal to the 3x3 window sums modulo 256 (index 0 = 54, index 8 = 162); a single done pulse.
- Backpressure: win_ready low for 5 cycles at each request. Required: win_row/win_col held stable while win_ready is low; exactly 9 acceptances in raster order; no duplicated or skipped index.
- Outstanding limit: MAX_OUT=2, results delayed 10 cycles. Required: win_valid drops after 2 acceptances; it reasserts the cycle after the first res_valid; the outstanding count never exceeds 2.
- Simultaneous issue and return at the limit boundary. Required: counter unchanged in that cycle; final count 0 at done.
- Spurious result: res_valid in IDLE. Required: err=1 and stays 1; no out_valid; err cleared only by rst.
- Reset mid-run at cycle 20, then start again. Required: all outputs 0 the cycle after rst; the second run restarts the kernel reads at KERN_BASE and completes normally; start pulses while busy produce no effect.
